// File: rtl/pry2oht_scan_if.sv
// rtl/pry2oht_scan_if.sv - request-vector in / one-hot item out handshake bundle
interface pry2oht_scan_if #(
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             vec_vld;
  logic [WIDTH-1:0] vec;
  logic             vec_rdy;
  logic             oht_vld;
  logic [WIDTH-1:0] oht;
  logic [IDX_W-1:0] idx;
  logic             lst;
  logic             oht_rdy;

  modport master (
    output vec_vld, vec, oht_rdy,
    input  vec_rdy, oht_vld, oht, idx, lst
  );

  modport slave (
    input  vec_vld, vec, oht_rdy,
    output vec_rdy, oht_vld, oht, idx, lst
  );
endinterface

// File: rtl/pry2oht_scan.sv
// rtl/pry2oht_scan.sv - emits the set bits of a request vector one per handshake, in priority order
module pry2oht #(
  parameter int    WIDTH          = 32,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] sel
);
  logic [WIDTH-1:0] fwd;
  logic [WIDTH-1:0] fsel;

  // MSB priority is LSB priority on the bit-reversed vector
  always_comb begin
    fwd = '0;
    sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fwd[i] = (DIRECTION == "MSB") ? req[WIDTH-1-i] : req[i];
      sel[i] = (DIRECTION == "MSB") ? fsel[WIDTH-1-i] : fsel[i];
    end
  end

  generate
    if (IMPLEMENTATION == 1) begin : g_arith
      assign fsel = fwd & (~fwd + WIDTH'(1));
    end else begin : g_loop
      always_comb begin
        logic found;
        found = 1'b0;
        fsel  = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (fwd[i] && !found) begin
            fsel[i] = 1'b1;
            found   = 1'b1;
          end
        end
      end
    end
  endgenerate
endmodule

module pry2oht_scan #(
  parameter int    WIDTH          = 32,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic           clk,
  input  logic           rst,
  pry2oht_scan_if.slave  bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [0:0] {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] sel;
  logic [IDX_W-1:0] sel_idx;

  logic             vec_rdy;
  logic             oht_vld;
  logic [WIDTH-1:0] oht;
  logic [IDX_W-1:0] idx;
  logic             lst;

  pry2oht #(
    .WIDTH          (WIDTH),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_pry2oht (
    .req (rem_q),
    .sel (sel)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel[i]) sel_idx = sel_idx | IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    oht_vld = 1'b0;
    oht     = '0;
    idx     = '0;
    lst     = 1'b0;
    vec_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        vec_rdy = 1'b1;
        if (bus.vec_vld && bus.vec != '0) begin
          rem_d   = bus.vec;
          state_d = SCAN;
        end
      end
      SCAN: begin
        oht_vld = 1'b1;
        oht     = sel;
        idx     = sel_idx;
        lst     = ((rem_q & ~sel) == '0);
        // the last item can hand over to the next vector in the same cycle
        vec_rdy = lst && bus.oht_rdy;
        if (bus.oht_rdy) begin
          rem_d = rem_q & ~sel;
          if (lst) begin
            if (bus.vec_vld && bus.vec != '0) begin
              rem_d = bus.vec;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  assign bus.vec_rdy = vec_rdy;
  assign bus.oht_vld = oht_vld;
  assign bus.oht     = oht;
  assign bus.idx     = idx;
  assign bus.lst     = lst;
endmodule
